// File: rtl/cargo_scheduler_pkg.sv
// Shared smart-cargo definitions: FSM encoding, request field layout and
// default sizing for the scheduler and its request FIFO.
package cargo_scheduler_pkg;

  localparam int unsigned DEPTH_DEF   = 16;
  localparam int unsigned DWELL_DEF   = 50;
  localparam int unsigned REQ_W       = 8;
  localparam int unsigned FLOOR_W     = 2;
  localparam int unsigned NUM_FLOORS  = 4;
  localparam int unsigned ORIGIN_LSB  = 0;
  localparam int unsigned DEST_LSB    = 2;
  localparam int unsigned OBJ_LSB     = 4;
  // Only origin/dest travel through the queue; obj is carried by the link but unused here.
  localparam int unsigned TRIP_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_GO_ORIGIN = 3'd2,
    ST_LOAD      = 3'd3,
    ST_GO_DEST   = 3'd4,
    ST_UNLOAD    = 3'd5
  } state_e;

  function automatic logic [FLOOR_W-1:0] trip_origin(input logic [TRIP_W-1:0] t);
    return t[ORIGIN_LSB +: FLOOR_W];
  endfunction

  function automatic logic [FLOOR_W-1:0] trip_dest(input logic [TRIP_W-1:0] t);
    return t[DEST_LSB +: FLOOR_W];
  endfunction

endpackage

// File: rtl/cargo_req_fifo.sv
// Circular request queue; a push while full is accepted only alongside a pop.
module cargo_req_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cargo_scheduler.sv
// Cargo lift scheduler: queues trip requests, tracks the cab floor and runs
// fetch / travel / dwell sequencing with an emergency freeze.
module cargo_scheduler
  import cargo_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned DWELL_CYCLES = DWELL_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   emergencia,
  input  logic [NUM_FLOORS-1:0]  sensoresNeg,
  input  logic                   req_valid,
  input  logic [REQ_W-1:0]       req_data,
  output logic                   req_drop,
  output logic                   motorSubindoF,
  output logic                   motorDescendoF,
  output logic [FLOOR_W-1:0]     saida_andar,
  output logic [$clog2(DEPTH):0] fila_count,
  output logic                   fila_cheia,
  output logic                   em_viagem,
  output logic                   viagem_fim
);

  localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);

  state_e              state_q, state_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [FLOOR_W-1:0]  andar_q, andar_d;
  logic [FLOOR_W-1:0]  origin_q, origin_d;
  logic [FLOOR_W-1:0]  dest_q, dest_d;
  logic                up_q, up_d;
  logic                dn_q, dn_d;
  logic                drop_q, drop_d;
  logic                fim_q, fim_d;
  logic                viagem_q, viagem_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TRIP_W-1:0]   fifo_head;
  logic [FLOOR_W-1:0]  target;
  logic                at_target;
  logic                unused_req_bits;

  assign unused_req_bits = ^req_data[REQ_W-1:TRIP_W];

  assign fifo_push = req_valid
                   && (trip_origin(req_data[TRIP_W-1:0]) != trip_dest(req_data[TRIP_W-1:0]))
                   && (!fifo_full || fifo_pop);

  cargo_req_fifo #(.DEPTH(DEPTH), .WIDTH(TRIP_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (req_data[TRIP_W-1:0]),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fila_count)
  );

  assign fila_cheia = fifo_full;

  // Floor register follows a single low sensor; ambiguous readings hold.
  always_comb begin
    andar_d = andar_q;
    case (~sensoresNeg)
      4'b0001: andar_d = 2'd0;
      4'b0010: andar_d = 2'd1;
      4'b0100: andar_d = 2'd2;
      4'b1000: andar_d = 2'd3;
      default: andar_d = andar_q;
    endcase
  end

  assign target    = (state_q == ST_GO_ORIGIN) ? origin_q : dest_q;
  assign at_target = (andar_q == target) && !sensoresNeg[target];

  // Next-state and registered-output logic; emergencia freezes everything but the queue.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    origin_d = origin_q;
    dest_d   = dest_q;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    fim_d    = 1'b0;
    fifo_pop = 1'b0;
    if (!emergencia) begin
      case (state_q)
        ST_IDLE: begin
          if (iniciar && !fifo_empty) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          fifo_pop = 1'b1;
          origin_d = trip_origin(fifo_head);
          dest_d   = trip_dest(fifo_head);
          state_d  = ST_GO_ORIGIN;
        end
        ST_GO_ORIGIN, ST_GO_DEST: begin
          if (at_target) begin
            dwell_d = '0;
            state_d = (state_q == ST_GO_ORIGIN) ? ST_LOAD : ST_UNLOAD;
          end else begin
            up_d = (target > andar_q);
            dn_d = (target < andar_q);
          end
        end
        ST_LOAD, ST_UNLOAD: begin
          if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
            dwell_d = '0;
            state_d = (state_q == ST_LOAD) ? ST_GO_DEST : ST_IDLE;
            fim_d   = (state_q == ST_UNLOAD);
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    drop_d   = req_valid && !fifo_push;
    viagem_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dwell_q  <= '0;
      andar_q  <= '0;
      origin_q <= '0;
      dest_q   <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      drop_q   <= 1'b0;
      fim_q    <= 1'b0;
      viagem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      andar_q  <= andar_d;
      origin_q <= origin_d;
      dest_q   <= dest_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      drop_q   <= drop_d;
      fim_q    <= fim_d;
      viagem_q <= viagem_d;
    end
  end

  assign motorSubindoF  = up_q;
  assign motorDescendoF = dn_q;
  assign req_drop       = drop_q;
  assign viagem_fim     = fim_q;
  assign em_viagem      = viagem_q;
  assign saida_andar    = andar_q;

endmodule

// File: tb/tb_cargo_scheduler.sv
// Directed bench for cargo_scheduler: vector table for queue/floor behaviour,
// hand-written sequences for trips, emergency freeze and mid-trip reset.
module tb_cargo_scheduler;

  logic       clock = 1'b0;
  logic       reset, iniciar, emergencia, req_valid;
  logic [3:0] sensoresNeg;
  logic [7:0] req_data;
  logic       req_drop, motorSubindoF, motorDescendoF, fila_cheia, em_viagem, viagem_fim;
  logic [1:0] saida_andar;
  logic [4:0] fila_count;

  int tests = 0;
  int fails = 0;
  int both_on_cnt = 0;
  int n;

  localparam int SIG_UP = 0;
  localparam int SIG_DN = 1;
  localparam int SIG_FIM = 2;

  always #5 clock = ~clock;

  cargo_scheduler #(.DEPTH(16), .DWELL_CYCLES(50)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .emergencia     (emergencia),
    .sensoresNeg    (sensoresNeg),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_drop       (req_drop),
    .motorSubindoF  (motorSubindoF),
    .motorDescendoF (motorDescendoF),
    .saida_andar    (saida_andar),
    .fila_count     (fila_count),
    .fila_cheia     (fila_cheia),
    .em_viagem      (em_viagem),
    .viagem_fim     (viagem_fim)
  );

  always @(negedge clock) if (motorSubindoF && motorDescendoF) both_on_cnt++;

  typedef struct {
    logic       v;
    logic [7:0] data;
    logic [3:0] sens;
    logic       exp_drop;
    int         exp_count;
    logic       exp_full;
    int         exp_floor;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      SIG_UP:  return motorSubindoF;
      SIG_DN:  return motorDescendoF;
      default: return viagem_fim;
    endcase
  endfunction

  // Ticks until the selected output reaches val; an expired budget is a failure.
  task automatic wait_for(input int which, input logic val, input int max_cyc,
                          input string name, output int cyc);
    cyc = 0;
    while (sig(which) !== val && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    tests++;
    if (sig(which) !== val) begin
      fails++;
      $display("FAIL %s: got timeout after %0d cycles expected level %0d", name, cyc, val);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; iniciar = 1'b0; emergencia = 1'b0; req_valid = 1'b0; req_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    req_valid = 1'b1; req_data = d;
    tick();
    req_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [3:0] s,
                              input logic drop, input int cnt, input logic full, input int fl);
    vec_t r;
    r.v = v; r.data = d; r.sens = s; r.exp_drop = drop;
    r.exp_count = cnt; r.exp_full = full; r.exp_floor = fl;
    return r;
  endfunction

  initial begin
    int drops;
    // Sensor/queue vector table (iniciar held low, so nothing is ever popped).
    vecs.push_back(mk(1'b0, 8'h00, 4'b1110, 1'b0, 0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 8'h15, 4'b1011, 1'b1, 0, 1'b0, 2));
    vecs.push_back(mk(1'b0, 8'h00, 4'b1111, 1'b0, 0, 1'b0, 2));
    vecs.push_back(mk(1'b0, 8'h00, 4'b1001, 1'b0, 0, 1'b0, 2));
    vecs.push_back(mk(1'b0, 8'h00, 4'b0111, 1'b0, 0, 1'b0, 3));
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mk(1'b1, 8'h1D, 4'b0111, 1'b0, i, (i == 16), 3));
    vecs.push_back(mk(1'b1, 8'h1D, 4'b0111, 1'b1, 16, 1'b1, 3));
    vecs.push_back(mk(1'b1, 8'h15, 4'b0111, 1'b1, 16, 1'b1, 3));
    vecs.push_back(mk(1'b0, 8'h00, 4'b0111, 1'b0, 16, 1'b1, 3));

    // Reset state, with a sensor pattern that would otherwise load floor 2.
    sensoresNeg = 4'b1011;
    do_reset();
    reset = 1'b1;
    tick();
    check("reset_outputs",
          int'({motorSubindoF, motorDescendoF, req_drop, viagem_fim, em_viagem, fila_cheia}), 0);
    check("reset_floor", int'(saida_andar), 0);
    check("reset_count", int'(fila_count), 0);
    reset = 1'b0;

    drops = 0;
    foreach (vecs[i]) begin
      sensoresNeg = vecs[i].sens;
      req_valid   = vecs[i].v;
      req_data    = vecs[i].data;
      tick();
      req_valid = 1'b0;
      check($sformatf("vec%0d_drop", i),  int'(req_drop),    int'(vecs[i].exp_drop));
      check($sformatf("vec%0d_count", i), int'(fila_count),  vecs[i].exp_count);
      check($sformatf("vec%0d_full", i),  int'(fila_cheia),  int'(vecs[i].exp_full));
      check($sformatf("vec%0d_floor", i), int'(saida_andar), vecs[i].exp_floor);
      if (i >= 5 && i <= 21 && req_drop) drops++;
    end
    check("seventeen_pushes_one_drop", drops, 1);

    // Single trip 1 -> 3 from floor 0 with dwell timing.
    sensoresNeg = 4'b1110;
    do_reset();
    iniciar = 1'b1;
    push(8'h1D);
    wait_for(SIG_UP, 1'b1, 10, "trip_up_to_origin", n);
    check("trip_no_down", int'(motorDescendoF), 0);
    check("trip_em_viagem", int'(em_viagem), 1);
    check("trip_popped", int'(fila_count), 0);
    sensoresNeg = 4'b1101;
    wait_for(SIG_UP, 1'b0, 5, "trip_stop_origin", n);
    check("trip_floor1", int'(saida_andar), 1);
    // Motors stay off through 50 LOAD cycles plus one registered cycle in GO_DEST.
    wait_for(SIG_UP, 1'b1, 100, "trip_up_to_dest", n);
    check("load_dwell", n, 51);
    sensoresNeg = 4'b0111;
    wait_for(SIG_UP, 1'b0, 5, "trip_stop_dest", n);
    wait_for(SIG_FIM, 1'b1, 100, "trip_viagem_fim", n);
    check("unload_dwell", n, 50);
    check("trip_idle_at_end", int'(em_viagem), 0);
    tick();
    check("viagem_fim_one_cycle", int'(viagem_fim), 0);
    check("trip_floor3", int'(saida_andar), 3);

    // Emergency freeze in GO_DEST.
    sensoresNeg = 4'b1110;
    do_reset();
    iniciar = 1'b1;
    push(8'h1D);
    wait_for(SIG_UP, 1'b1, 10, "emg_up_origin", n);
    sensoresNeg = 4'b1101;
    wait_for(SIG_UP, 1'b0, 5, "emg_stop_origin", n);
    wait_for(SIG_UP, 1'b1, 100, "emg_go_dest", n);
    emergencia = 1'b1;
    tick();
    check("emg_motors_off", int'({motorSubindoF, motorDescendoF}), 0);
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (motorSubindoF || motorDescendoF || !em_viagem || viagem_fim) bad++;
      end
      check("emg_hold_100", bad, 0);
    end
    emergencia = 1'b0;
    wait_for(SIG_UP, 1'b1, 3, "emg_resume_up", n);
    sensoresNeg = 4'b0111;
    wait_for(SIG_FIM, 1'b1, 200, "emg_trip_done", n);

    // Two trips served in FIFO order.
    sensoresNeg = 4'b1110;
    do_reset();
    push(8'h1D);
    push(8'h1E);
    check("order_count2", int'(fila_count), 2);
    iniciar = 1'b1;
    wait_for(SIG_UP, 1'b1, 10, "order_t1_up", n);
    check("order_t1_pop", int'(fila_count), 1);
    sensoresNeg = 4'b1101;
    wait_for(SIG_UP, 1'b0, 5, "order_t1_origin", n);
    wait_for(SIG_UP, 1'b1, 100, "order_t1_dest", n);
    sensoresNeg = 4'b0111;
    wait_for(SIG_FIM, 1'b1, 100, "order_t1_fim", n);
    check("order_t2_not_started", int'(fila_count), 1);
    wait_for(SIG_DN, 1'b1, 10, "order_t2_down", n);
    check("order_t2_pop", int'(fila_count), 0);
    sensoresNeg = 4'b1011;
    wait_for(SIG_DN, 1'b0, 5, "order_t2_origin", n);
    wait_for(SIG_UP, 1'b1, 100, "order_t2_dest_up", n);
    sensoresNeg = 4'b0111;
    wait_for(SIG_FIM, 1'b1, 100, "order_t2_fim", n);

    // Reset during LOAD discards the trip and the queue.
    sensoresNeg = 4'b1110;
    do_reset();
    push(8'h1D);
    push(8'h1E);
    iniciar = 1'b1;
    wait_for(SIG_UP, 1'b1, 10, "rst_up", n);
    sensoresNeg = 4'b1101;
    wait_for(SIG_UP, 1'b0, 5, "rst_in_load", n);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    check("rst_idle", int'(em_viagem), 0);
    check("rst_count", int'(fila_count), 0);
    check("rst_motors", int'({motorSubindoF, motorDescendoF}), 0);
    check("rst_floor", int'(saida_andar), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_stays_idle", int'(em_viagem), 0);

    check("motors_exclusive", both_on_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cargo_scheduler.md
CARGO_SCHEDULER -- requirements
Module: cargo_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 16: request-queue entries (power of two).
REQ-002 SHALL have parameter DWELL_CYCLES, default 50: load/unload dwell, in clock cycles.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port iniciar, input, 1: enables fetching of new trips.
REQ-006 SHALL have port emergencia, input, 1: level; freezes motion while high.
REQ-007 SHALL have port sensoresNeg, input, 4: active-low floor sensors; bit i low means the cab is at floor i.
REQ-008 SHALL have port req_valid, input, 1: single-cycle strobe from the serial receiver.
REQ-009 SHALL have port req_data, input, 8: {2'b00, obj[5:4], dest[3:2], origin[1:0]}.
REQ-010 SHALL have port req_drop, output, 1: one-cycle pulse when a strobed request is rejected.
REQ-011 SHALL have ports motorSubindoF / motorDescendoF, output, 1 each: up/down motor commands.
REQ-012 SHALL have port saida_andar, output, 2: last confirmed floor.
REQ-013 SHALL have ports fila_count (output, 5: queued entries) and fila_cheia (output, 1: count==DEPTH).
REQ-014 SHALL have ports em_viagem (output, 1: trip active) and viagem_fim (output, 1: one-cycle pulse at unload end).

Function
REQ-015 SHALL set floor register andar_atual to i when exactly one sensoresNeg bit i is low; all-high or multiple-low SHALL hold the previous value.
REQ-016 SHALL push req_data into a circular FIFO (write pointer and read pointer mod DEPTH) on req_valid when not full and origin!=dest.
REQ-017 SHALL pulse req_drop the next cycle, without a push, when the FIFO is full or origin==dest.
REQ-018 SHALL accept a push in the same cycle as a pop when full; fila_count stays DEPTH.
REQ-019 SHALL use FSM states IDLE, FETCH, GO_ORIGIN, LOAD, GO_DEST, UNLOAD.
REQ-020 SHALL go IDLE->FETCH when iniciar=1, fila_count>0 and emergencia=0.
REQ-021 SHALL pop the head entry in FETCH, latch origin/dest, then go to GO_ORIGIN.
REQ-022 SHALL drive, in GO_x, motorSubindoF=1 if target>andar_atual and motorDescendoF=1 if target<andar_atual (registered, one cycle after the state is entered).
REQ-023 SHALL, when andar_atual==target and sensoresNeg[target]==0, set both motors to 0 and go GO_ORIGIN->LOAD or GO_DEST->UNLOAD.
REQ-024 SHALL make LOAD and UNLOAD each last exactly DWELL_CYCLES cycles; LOAD->GO_DEST; UNLOAD->IDLE with viagem_fim pulsed for one cycle.
REQ-025 SHALL never assert motorSubindoF and motorDescendoF together.
REQ-026 SHALL drop both motors to 0 within one cycle of emergencia=1, and freeze state and dwell counter; on release, resume the same state.
REQ-027 SHALL continue FIFO pushes during emergencia.
REQ-028 SHALL let an in-progress trip complete when iniciar falls; only IDLE->FETCH is gated by iniciar.
REQ-029 SHALL assert em_viagem in every state except IDLE.

Reset
REQ-030 SHALL, while reset=1, clear FIFO pointers and count, set state=IDLE, andar_atual=0, all outputs 0 and saida_andar=0.
REQ-031 SHALL discard any active trip when reset is asserted mid-operation; motors are 0 in the cycle after reset is sampled.

Structure
REQ-032 SHALL place the FSM state encoding, the req_data field positions and DEPTH/DWELL defaults in the shared smart-cargo package.
REQ-033 SHALL implement the FIFO as sub-module cargo_req_fifo (push/pop/full/empty/count); the FSM and floor tracking stay in the top.

Verification
REQ-034 SHALL check that from reset at floor 0, a push of 8'h1D (origin 1, dest 3) with iniciar=1 gives motorSubindoF until sensoresNeg=4'b1101, then LOAD 50 cycles, then up to 4'b0111, UNLOAD 50 cycles, and a viagem_fim pulse.
REQ-035 SHALL check that 17 valid pushes on an empty FIFO with iniciar=0 give fila_count=16, fila_cheia=1 and exactly one req_drop.
REQ-036 SHALL check that a push of 8'h15 (origin==dest==1) gives req_drop=1 and an unchanged fila_count.
REQ-037 SHALL check that emergencia=1 mid-GO_DEST drops both motors within 1 cycle, holds the state for 100 cycles, and resumes the same direction after release.
REQ-038 SHALL check that pushes of 8'h1D and then 8'h1E are served in FIFO order; the second trip starts only after the first viagem_fim.
REQ-039 SHALL check that reset asserted during LOAD gives state IDLE, fila_count=0 and motors 0 on the next cycle.
